// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
// Bit-serial subtractor: computes a - b (unsigned, modulo 2^WIDTH) LSB first,
// one bit per clock, using a single borrow-chained subtractor cell.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_ni        synchronous active-low reset
//   start_i       operation request, honoured only while idle
//   a_i, b_i      minuend / subtrahend, captured on the accepting edge
//   busy_o        high while an operation is in flight (SHIFT or DONE)
//   done_o        one-cycle pulse when diff_o / borrow_out_o are updated
//   diff_o        (a - b) mod 2^WIDTH of the last completed operation
//   borrow_out_o  borrow out of the MSB (1 iff a < b)
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Subtractor cell: returns {borrow_out, difference_bit}.
  function automatic logic [1:0] sub_cell(input logic a, input logic b, input logic bin);
    logic d;
    logic bout;
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
    return {bout, d};
  endfunction

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic [1:0]       cell_s;
  logic [WIDTH-1:0] res_shift_s;

  // Next-state, datapath and output-register logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    cell_s = sub_cell(a_q[0], b_q[0], borrow_q);
    // New bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
    res_shift_s = res_q >> 1;
    res_shift_s[WIDTH-1] = cell_s[0];

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d  = ST_SHIFT;
          a_d      = a_i;
          b_d      = b_i;
          res_d    = '0;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        res_d    = res_shift_s;
        borrow_d = cell_s[1];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Result becomes visible only once complete.
          state_d = ST_DONE;
          diff_d  = res_shift_s;
          bout_d  = cell_s[1];
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign diff_o       = diff_q;
  assign borrow_out_o = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Testbench for serial_subtractor_ctrl: a WIDTH=8 and a WIDTH=1 instance are
// compared every cycle against a transaction-level model (age of the current
// operation in edges, result from plain integer arithmetic), plus literal
// expectations for the directed operations.
module tb_serial_subtractor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_s [2] = '{1'b0, 1'b0};
  logic [7:0] a_s [2] = '{8'h00, 8'h00};
  logic [7:0] b_s [2] = '{8'h00, 8'h00};

  logic       busy8, done8, bor8;
  logic [7:0] diff8;
  logic       busy1, done1, bor1;
  logic [0:0] diff1;

  int checks = 0;
  int errors = 0;
  int dn_count = 0;

  // Model state: age = edges since acceptance (-1 when idle).
  int wid   [2] = '{8, 1};
  int age   [2] = '{-1, -1};
  int pa    [2] = '{0, 0};
  int pb    [2] = '{0, 0};
  int ediff [2] = '{0, 0};
  int ebor  [2] = '{0, 0};

  // Expected literal results, encoded diff*2+borrow.
  int lit0 [$];
  int lit1 [$];

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[0]),
    .a_i(a_s[0]), .b_i(b_s[0]),
    .busy_o(busy8), .done_o(done8), .diff_o(diff8), .borrow_out_o(bor8)
  );

  serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_s[1]),
    .a_i(a_s[1][0:0]), .b_i(b_s[1][0:0]),
    .busy_o(busy1), .done_o(done1), .diff_o(diff1), .borrow_out_o(bor1)
  );

  always #5 clk = ~clk;

  // Behavioural model, advanced on each rising edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        age[i] = -1; ediff[i] = 0; ebor[i] = 0;
      end else if (age[i] < 0) begin
        if (start_s[i]) begin
          age[i] = 0;
          pa[i] = int'(a_s[i]) % (1 << wid[i]);
          pb[i] = int'(b_s[i]) % (1 << wid[i]);
        end
      end else if (age[i] == wid[i]) begin
        age[i] = -1;
      end else begin
        age[i] = age[i] + 1;
        if (age[i] == wid[i]) begin
          ediff[i] = (pa[i] - pb[i] + (1 << wid[i])) % (1 << wid[i]);
          ebor[i]  = (pa[i] < pb[i]) ? 1 : 0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: wait for the falling edge and compare everything.
  task automatic tick();
    int v;
    @(negedge clk);
    chk("busy8", {31'd0, busy8}, {31'd0, age[0] >= 0});
    chk("done8", {31'd0, done8}, {31'd0, age[0] == 8});
    chk("diff8", {24'd0, diff8}, ediff[0]);
    chk("bor8",  {31'd0, bor8},  ebor[0]);
    chk("busy1", {31'd0, busy1}, {31'd0, age[1] >= 0});
    chk("done1", {31'd0, done1}, {31'd0, age[1] == 1});
    chk("diff1", {31'd0, diff1}, ediff[1]);
    chk("bor1",  {31'd0, bor1},  ebor[1]);
    if (age[0] == 8 && lit0.size() > 0) begin
      v = lit0.pop_front();
      chk("lit_diff8",  {24'd0, diff8}, v >> 1);
      chk("lit_bor8",   {31'd0, bor8},  v & 1);
      chk("model_diff8", ediff[0], v >> 1);
    end
    if (age[1] == 1 && lit1.size() > 0) begin
      v = lit1.pop_front();
      chk("lit_diff1",  {31'd0, diff1}, v >> 1);
      chk("lit_bor1",   {31'd0, bor1},  v & 1);
      chk("model_diff1", ediff[1], v >> 1);
    end
    if (done8) dn_count++;
  endtask

  task automatic op(input int i, input logic [7:0] a, input logic [7:0] b, input int lit);
    if (i == 0) lit0.push_back(lit); else lit1.push_back(lit);
    start_s[i] = 1'b1; a_s[i] = a; b_s[i] = b;
    tick();
    start_s[i] = 1'b0; a_s[i] = 8'($urandom); b_s[i] = 8'($urandom);
    repeat (wid[i] + 1) tick();
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Basic subtraction, then wrap-around and equal operands.
    op(0, 8'h5A, 8'h3C, 32'h1E * 2 + 0);
    op(0, 8'h00, 8'h01, 32'hFF * 2 + 1);
    op(0, 8'h80, 8'h80, 32'h00 * 2 + 0);

    // WIDTH=1 truth table.
    op(1, 8'h00, 8'h00, 0 * 2 + 0);
    op(1, 8'h00, 8'h01, 1 * 2 + 1);
    op(1, 8'h01, 8'h00, 1 * 2 + 0);
    op(1, 8'h01, 8'h01, 0 * 2 + 0);

    // Starts at E2 and E_WIDTH+1 must be ignored.
    lit0.push_back(32'h22 * 2 + 0);
    dn_count = 0;
    for (int k = 0; k <= 9; k++) begin
      start_s[0] = (k == 0 || k == 2 || k == 9);
      a_s[0] = (k == 0) ? 8'h33 : 8'($urandom);
      b_s[0] = (k == 0) ? 8'h11 : 8'($urandom);
      tick();
    end
    start_s[0] = 1'b0;
    tick();
    chk("one_done", dn_count, 1);

    // Reset at E4 aborts the operation.
    for (int k = 0; k < 4; k++) begin
      start_s[0] = (k == 0); a_s[0] = 8'h77; b_s[0] = 8'h12;
      tick();
    end
    start_s[0] = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("rst_busy8", {31'd0, busy8}, 0);
    chk("rst_diff8", {24'd0, diff8}, 0);
    rst_n = 1'b1;
    dn_count = 0;
    tick();
    chk("abort_no_done", dn_count, 0);
    op(0, 8'hFF, 8'h0F, 32'hF0 * 2 + 0);

    // Continuous start with varying operands.
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 2; i++) begin
        start_s[i] = 1'b1; a_s[i] = 8'($urandom); b_s[i] = 8'($urandom);
      end
      tick();
    end

    // Random starts with occasional resets.
    for (int k = 0; k < 600; k++) begin
      rst_n = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < 2; i++) begin
        start_s[i] = $urandom_range(0, 1) == 1;
        a_s[i] = 8'($urandom); b_s[i] = 8'($urandom);
      end
      tick();
    end

    rst_n = 1'b1;
    start_s[0] = 1'b0; start_s[1] = 1'b0;
    repeat (12) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
